// File: rtl/stepper_move_ctrl.sv
// Trapezoidal step-pulse generator feeding the 4-phase stepper sequencer.
// Accepts (steps, dir) moves and ramps the step period between PERIOD_MAX and PERIOD_MIN.
module stepper_move_ctrl #(
    parameter int CNT_W      = 27,
    parameter int STEP_W     = 16,
    parameter int PERIOD_MAX = 5000000,
    parameter int PERIOD_MIN = 500000,
    parameter int ACCEL_DEC  = 50000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_dir,
    input  logic [STEP_W-1:0]        cmd_steps,
    input  logic                     abort,
    output logic                     step,
    output logic                     dir,
    output logic                     enable,
    output logic                     busy,
    output logic                     done,
    output logic signed [STEP_W-1:0] pos
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEL,
        S_CRUISE,
        S_DECEL,
        S_DONE
    } state_t;

    localparam logic [CNT_W:0]         P_MAX_X = (CNT_W+1)'(PERIOD_MAX);
    localparam logic [CNT_W:0]         P_MIN_X = (CNT_W+1)'(PERIOD_MIN);
    localparam logic [CNT_W:0]         DEC_X   = (CNT_W+1)'(ACCEL_DEC);
    localparam logic [CNT_W-1:0]       P_MAX   = CNT_W'(PERIOD_MAX);
    localparam logic [CNT_W-1:0]       P_MIN   = CNT_W'(PERIOD_MIN);
    localparam logic signed [STEP_W-1:0] POS_ONE = STEP_W'(1);

    // One extra bit keeps the ramp arithmetic from wrapping before the clamp.
    function automatic logic [CNT_W-1:0] period_faster(input logic [CNT_W-1:0] p);
        logic [CNT_W:0] wide;
        logic [CNT_W-1:0] res;
        wide = {1'b0, p};
        if (wide < P_MIN_X + DEC_X)
            res = P_MIN;
        else
            res = CNT_W'(wide - DEC_X);
        return res;
    endfunction

    function automatic logic [CNT_W-1:0] period_slower(input logic [CNT_W-1:0] p);
        logic [CNT_W:0] wide;
        logic [CNT_W-1:0] res;
        wide = {1'b0, p} + DEC_X;
        if (wide > P_MAX_X)
            res = P_MAX;
        else
            res = CNT_W'(wide);
        return res;
    endfunction

    function automatic logic [STEP_W-1:0] sat_dec(input logic [STEP_W-1:0] v);
        return (v == '0) ? '0 : v - STEP_W'(1);
    endfunction

    state_t              r_state;
    logic [CNT_W-1:0]    r_period;
    logic [CNT_W-1:0]    r_tick;
    logic [STEP_W-1:0]   r_remaining;
    logic [STEP_W-1:0]   r_ramp_cnt;

    logic                w_event;
    logic [STEP_W-1:0]   w_rem_dec;
    logic [STEP_W-1:0]   w_ramp_inc;
    logic [STEP_W-1:0]   w_ramp_dec;
    logic [CNT_W-1:0]    w_period_fast;
    logic [CNT_W-1:0]    w_period_slow;
    state_t              w_nxt_state;
    logic [CNT_W-1:0]    w_nxt_period;
    logic [STEP_W-1:0]   w_nxt_rem;
    logic [STEP_W-1:0]   w_nxt_ramp;

    assign w_event       = (r_tick == r_period - CNT_W'(1));
    assign w_rem_dec     = sat_dec(r_remaining);
    assign w_ramp_inc    = r_ramp_cnt + STEP_W'(1);
    assign w_ramp_dec    = sat_dec(r_ramp_cnt);
    assign w_period_fast = period_faster(r_period);
    assign w_period_slow = period_slower(r_period);

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_period = r_period;
        w_nxt_rem    = r_remaining;
        w_nxt_ramp   = r_ramp_cnt;
        case (r_state)
            S_ACCEL: if (w_event) begin
                w_nxt_rem    = w_rem_dec;
                w_nxt_period = w_period_fast;
                w_nxt_ramp   = w_ramp_inc;
                if (w_rem_dec == '0)
                    w_nxt_state = S_DONE;
                else if (w_rem_dec <= w_ramp_inc)
                    w_nxt_state = S_DECEL;
                else if (w_period_fast == P_MIN)
                    w_nxt_state = S_CRUISE;
            end
            S_CRUISE: if (w_event) begin
                w_nxt_rem = w_rem_dec;
                if (w_rem_dec == '0)
                    w_nxt_state = S_DONE;
                else if (w_rem_dec <= r_ramp_cnt)
                    w_nxt_state = S_DECEL;
            end
            S_DECEL: if (w_event) begin
                w_nxt_rem    = w_rem_dec;
                w_nxt_period = w_period_slow;
                w_nxt_ramp   = w_ramp_dec;
                if (w_rem_dec == '0)
                    w_nxt_state = S_DONE;
            end
            default: ;
        endcase
        // Abort leaves exactly enough steps to unwind the ramp taken so far.
        if ((r_state == S_ACCEL || r_state == S_CRUISE) && abort && w_nxt_state != S_DONE) begin
            w_nxt_rem   = w_nxt_ramp;
            w_nxt_state = (w_nxt_ramp == '0) ? S_DONE : S_DECEL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_period    <= P_MAX;
            r_tick      <= '0;
            r_remaining <= '0;
            r_ramp_cnt  <= '0;
            cmd_ready   <= 1'b1;
            step        <= 1'b0;
            dir         <= 1'b0;
            enable      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pos         <= '0;
        end else begin
            step <= 1'b0;
            done <= 1'b0;
            case (r_state)
                S_IDLE: if (cmd_valid) begin
                    dir       <= cmd_dir;
                    busy      <= 1'b1;
                    cmd_ready <= 1'b0;
                    if (cmd_steps == '0) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end else begin
                        r_state     <= S_ACCEL;
                        r_remaining <= cmd_steps;
                        r_period    <= P_MAX;
                        r_tick      <= '0;
                        r_ramp_cnt  <= '0;
                        enable      <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    r_state     <= w_nxt_state;
                    r_period    <= w_nxt_period;
                    r_remaining <= w_nxt_rem;
                    r_ramp_cnt  <= w_nxt_ramp;
                    r_tick      <= w_event ? '0 : r_tick + CNT_W'(1);
                    if (w_event) begin
                        step <= 1'b1;
                        pos  <= dir ? pos + POS_ONE : pos - POS_ONE;
                    end
                    if (w_nxt_state == S_DONE) begin
                        done   <= 1'b1;
                        enable <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Directed bench for stepper_move_ctrl with a short ramp (PERIOD 10..4, step 2).
module tb_stepper_move_ctrl;

    localparam int STEP_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0;
    logic cmd_dir = 1'b0;
    logic abort = 1'b0;
    logic [STEP_W-1:0] cmd_steps = '0;
    logic cmd_ready, step, dir, enable, busy, done;
    logic signed [STEP_W-1:0] pos;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int t_acc = 0;
    int t_done = 0;
    int nstep = 0;
    int ivl [0:31];
    bit done_with_step;
    bit dir_bad;
    bit finished;
    int exp_trap [0:7] = '{10, 8, 6, 4, 4, 4, 6, 8};
    int exp_abort [0:3] = '{10, 8, 6, 8};

    stepper_move_ctrl #(
        .CNT_W(27),
        .STEP_W(STEP_W),
        .PERIOD_MAX(10),
        .PERIOD_MIN(4),
        .ACCEL_DEC(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir),
        .cmd_steps(cmd_steps),
        .abort(abort),
        .step(step),
        .dir(dir),
        .enable(enable),
        .busy(busy),
        .done(done),
        .pos(pos)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    // Present a command on a falling edge; t_acc is the falling edge after acceptance.
    task automatic issue(input bit d, input int n, input bit keep);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dir   = d;
        cmd_steps = 16'(n);
        @(negedge clk);
        t_acc = cyc;
        if (!keep) cmd_valid = 1'b0;
    endtask

    // Follow a move from t_acc until done (or stop_at steps), logging step intervals.
    task automatic wait_done(input int abort_after, input int stop_at, input bit exp_dir);
        int prev;
        int k;
        prev = t_acc;
        k = 0;
        nstep = 0;
        done_with_step = 1'b0;
        dir_bad = 1'b0;
        finished = 1'b0;
        if (abort_after == 0) abort = 1'b1;
        while (!finished && k < 300) begin
            if (dir !== exp_dir) dir_bad = 1'b1;
            if (step === 1'b1) begin
                if (nstep < 32) ivl[nstep] = cyc - prev;
                prev = cyc;
                nstep++;
                if (nstep == abort_after) abort = 1'b1;
            end
            if (done === 1'b1) begin
                finished = 1'b1;
                t_done = cyc;
                done_with_step = (step === 1'b1);
            end
            if (stop_at != 0 && nstep == stop_at) finished = 1'b1;
            if (!finished) begin
                @(negedge clk);
                k++;
            end
        end
        abort = 1'b0;
        check("move_timeout", 32'(finished), 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_step", 32'(step), 0);
        check("rst_dir", 32'(dir), 0);
        check("rst_enable", 32'(enable), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pos", {16'h0, pos}, 0);
        check("rst_ready", 32'(cmd_ready), 1);
        rst = 1'b0;

        // Full trapezoid, 8 forward steps
        issue(1'b1, 8, 1'b0);
        check("t1_busy", 32'(busy), 1);
        check("t1_enable", 32'(enable), 1);
        check("t1_ready", 32'(cmd_ready), 0);
        wait_done(-1, 0, 1'b1);
        check("t1_nstep", nstep, 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("t1_ivl%0d", i), ivl[i], exp_trap[i]);
        check("t1_done_with_step", 32'(done_with_step), 1);
        check("t1_total", t_done - t_acc, 50);
        check("t1_pos", {16'h0, pos}, 8);
        check("t1_dir_stable", 32'(dir_bad), 0);
        @(negedge clk);
        check("t1_done_1cyc", 32'(done), 0);
        check("t1_ready_back", 32'(cmd_ready), 1);
        check("t1_busy_off", 32'(busy), 0);
        check("t1_enable_off", 32'(enable), 0);

        // Single step, then zero-step command
        issue(1'b1, 1, 1'b0);
        wait_done(-1, 0, 1'b1);
        check("t2_nstep", nstep, 1);
        check("t2_ivl", ivl[0], 10);
        check("t2_done_with_step", 32'(done_with_step), 1);
        check("t2_pos", {16'h0, pos}, 9);
        issue(1'b1, 0, 1'b0);
        wait_done(-1, 0, 1'b1);
        check("t2z_nstep", nstep, 0);
        check("t2z_done_lat", t_done - t_acc, 0);
        check("t2z_pos", {16'h0, pos}, 9);

        // Abort after two steps, then abort before the first step
        issue(1'b1, 100, 1'b0);
        wait_done(2, 0, 1'b1);
        check("t3_nstep", nstep, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t3_ivl%0d", i), ivl[i], exp_abort[i]);
        check("t3_pos", {16'h0, pos}, 13);
        issue(1'b1, 100, 1'b0);
        wait_done(0, 0, 1'b1);
        check("t3b_nstep", nstep, 0);
        check("t3b_done_lat", t_done - t_acc, 1);
        check("t3b_pos", {16'h0, pos}, 13);

        // Reverse from zero with a rejected command while busy
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t4_pos_clr", {16'h0, pos}, 0);
        rst = 1'b0;
        issue(1'b0, 3, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_steps = 16'd5;
        check("t4_ready_busy", 32'(cmd_ready), 0);
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(-1, 0, 1'b0);
        check("t4_nstep", nstep, 3);
        check("t4_ivl0", ivl[0], 10);
        check("t4_ivl1", ivl[1], 8);
        check("t4_ivl2", ivl[2], 6);
        check("t4_pos", {16'h0, pos}, 32'h0000FFFD);
        check("t4_dir_stable", 32'(dir_bad), 0);

        // Reset during cruise
        issue(1'b1, 8, 1'b0);
        wait_done(-1, 4, 1'b1);
        check("t5_nstep", nstep, 4);
        rst = 1'b1;
        @(negedge clk);
        check("t5_step", 32'(step), 0);
        check("t5_enable", 32'(enable), 0);
        check("t5_pos", {16'h0, pos}, 0);
        check("t5_ready", 32'(cmd_ready), 1);
        rst = 1'b0;
        issue(1'b1, 2, 1'b0);
        wait_done(-1, 0, 1'b1);
        check("t5b_nstep", nstep, 2);
        check("t5b_ivl0", ivl[0], 10);
        check("t5b_ivl1", ivl[1], 8);
        check("t5b_pos", {16'h0, pos}, 2);

        // Back-to-back with cmd_valid held high
        issue(1'b1, 2, 1'b1);
        wait_done(-1, 0, 1'b1);
        check("t6a_ivl0", ivl[0], 10);
        check("t6a_ivl1", ivl[1], 8);
        @(negedge clk);
        check("t6_ready", 32'(cmd_ready), 1);
        check("t6_done_off", 32'(done), 0);
        @(negedge clk);
        t_acc = cyc;
        check("t6_accept_busy", 32'(busy), 1);
        check("t6_accept_gap", t_acc - t_done, 2);
        cmd_valid = 1'b0;
        wait_done(-1, 0, 1'b1);
        check("t6b_nstep", nstep, 2);
        check("t6b_ivl0", ivl[0], 10);
        check("t6b_ivl1", ivl[1], 8);
        check("t6b_pos", {16'h0, pos}, 6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
